// File: rtl/classify_pkg.sv
// Shared types and constants for the classify_scorer slice: FSM state encoding,
// index-width helper and default parameter values.
package classify_pkg;

   localparam int DEF_NUM_CLASSES = 10;
   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_CNT_WIDTH   = 16;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   // max(1, clog2(n)): a class index always needs at least one bit
   function automatic int idx_w(input int n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/classify_scorer_if.sv
// Score-beat and result handshake bundle for classify_scorer.
// result_margin exists only when CLASSIFY_SCORER_MARGIN_EN is defined.
interface classify_scorer_if
   import classify_pkg::*;
#(
   parameter int NUM_CLASSES = DEF_NUM_CLASSES,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) ();

   localparam int IDX_W = idx_w(NUM_CLASSES);

   logic                         score_valid;
   logic                         score_ready;
   logic signed [DATA_WIDTH-1:0] score_data;
   logic        [IDX_W-1:0]      label_in;

   logic                         result_valid;
   logic                         result_ready;
   logic        [IDX_W-1:0]      result_label;
   logic signed [DATA_WIDTH-1:0] result_max;
   logic                         result_correct;
`ifdef CLASSIFY_SCORER_MARGIN_EN
   logic        [DATA_WIDTH:0]   result_margin;

   modport master (
      output score_valid, score_data, label_in, result_ready,
      input  score_ready, result_valid, result_label, result_max, result_correct, result_margin
   );

   modport slave (
      input  score_valid, score_data, label_in, result_ready,
      output score_ready, result_valid, result_label, result_max, result_correct, result_margin
   );
`else
   modport master (
      output score_valid, score_data, label_in, result_ready,
      input  score_ready, result_valid, result_label, result_max, result_correct
   );

   modport slave (
      input  score_valid, score_data, label_in, result_ready,
      output score_ready, result_valid, result_label, result_max, result_correct
   );
`endif

endinterface

// File: rtl/classify_scorer_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment)
// and asynchronous active-high reset.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/classify_scorer.sv
// Streaming argmax scorer: one signed class score per beat, reports winning class,
// its score and label match; optional max-minus-second margin via CLASSIFY_SCORER_MARGIN_EN.
module classify_scorer
   import classify_pkg::*;
#(
   parameter int NUM_CLASSES = DEF_NUM_CLASSES,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_stats,
   output logic [CNT_WIDTH-1:0] correct_cnt,
   output logic [CNT_WIDTH-1:0] total_cnt,
   classify_scorer_if.slave     bus
);

   localparam int               IDX_W    = idx_w(NUM_CLASSES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   state_t state, state_nxt;
   logic   run;

   logic        [IDX_W-1:0]      cls;
   logic        [IDX_W-1:0]      run_idx;
   logic        [IDX_W-1:0]      label_cap;
   logic signed [DATA_WIDTH-1:0] run_max;

   logic                         beat;
   logic                         last_beat;
   logic                         first_beat;
   logic                         gt_max;
   logic                         hit;
   logic signed [DATA_WIDTH-1:0] nxt_max;
   logic        [IDX_W-1:0]      nxt_idx;
   logic        [IDX_W-1:0]      nxt_label;

`ifdef CLASSIFY_SCORER_MARGIN_EN
   localparam logic signed [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   logic signed [DATA_WIDTH-1:0] run_second;
   logic signed [DATA_WIDTH-1:0] nxt_second;
`endif

   // run holds score_ready low until the first edge after reset is released
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run <= 1'b0;
      end else begin
         run <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= COLLECT;
      end else begin
         state <= state_nxt;
      end
   end

   assign beat      = bus.score_valid && run && (state == COLLECT);
   assign last_beat = beat && (cls == LAST_IDX);

   always_comb begin
      state_nxt        = state;
      bus.score_ready  = 1'b0;
      bus.result_valid = 1'b0;
      case (state)
         COLLECT: begin
            bus.score_ready = run;
            if (last_beat) state_nxt = HOLD;
         end
         HOLD: begin
            bus.result_valid = 1'b1;
            if (bus.result_ready) state_nxt = COLLECT;
         end
         default: state_nxt = COLLECT;
      endcase
   end

   // Candidate running state including the beat currently on the bus
   always_comb begin
      first_beat = (cls == '0);
      gt_max     = (bus.score_data > run_max);
      nxt_max    = (first_beat || gt_max) ? bus.score_data : run_max;
      nxt_idx    = first_beat ? '0 : (gt_max ? cls : run_idx);
      nxt_label  = first_beat ? bus.label_in : label_cap;
      hit        = (nxt_label == nxt_idx);
`ifdef CLASSIFY_SCORER_MARGIN_EN
      if (first_beat) begin
         nxt_second = MIN_SCORE;
      end else if (gt_max) begin
         nxt_second = run_max;
      end else if (bus.score_data > run_second) begin
         nxt_second = bus.score_data;
      end else begin
         nxt_second = run_second;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cls                <= '0;
         run_idx            <= '0;
         run_max            <= '0;
         label_cap          <= '0;
         bus.result_label   <= '0;
         bus.result_max     <= '0;
         bus.result_correct <= 1'b0;
`ifdef CLASSIFY_SCORER_MARGIN_EN
         run_second         <= '0;
         bus.result_margin  <= '0;
`endif
      end else if (beat) begin
         cls       <= last_beat ? '0 : cls + 1'b1;
         run_idx   <= nxt_idx;
         run_max   <= nxt_max;
         label_cap <= nxt_label;
`ifdef CLASSIFY_SCORER_MARGIN_EN
         run_second <= nxt_second;
`endif
         if (last_beat) begin
            bus.result_label   <= nxt_idx;
            bus.result_max     <= nxt_max;
            bus.result_correct <= hit;
`ifdef CLASSIFY_SCORER_MARGIN_EN
            // one extra bit so the full signed span fits as an unsigned difference
            bus.result_margin  <= {nxt_max[DATA_WIDTH-1], nxt_max}
                                - {nxt_second[DATA_WIDTH-1], nxt_second};
`endif
         end
      end
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_total_cnt (
      .clk (clk),
      .rst (rst),
      .inc (last_beat),
      .clr (clear_stats),
      .cnt (total_cnt)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_correct_cnt (
      .clk (clk),
      .rst (rst),
      .inc (last_beat && hit),
      .clr (clear_stats),
      .cnt (correct_cnt)
   );

endmodule

// File: tb/tb_classify_scorer.sv
// Randomized self-checking bench for classify_scorer (10 classes, 16-bit scores, 4-bit counters).
// Margin checks are compiled in when CLASSIFY_SCORER_MARGIN_EN is defined.
module tb_classify_scorer;
   import classify_pkg::*;

   localparam int NC = 10;
   localparam int DW = 16;
   localparam int CW = 4;
   localparam int IW = idx_w(NC);
   localparam int CNT_MAX = (1 << CW) - 1;

   typedef logic signed [DW-1:0] score_arr_t [NC];
   typedef struct {
      int label;
      int maxv;
      bit correct;
      int margin;
   } ref_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear_stats;
   logic [CW-1:0] correct_cnt;
   logic [CW-1:0] total_cnt;

   int n_pass   = 0;
   int n_checks = 0;
   int exp_total   = 0;
   int exp_correct = 0;

   classify_scorer_if #(.NUM_CLASSES(NC), .DATA_WIDTH(DW)) bus ();

   classify_scorer #(
      .NUM_CLASSES (NC),
      .DATA_WIDTH  (DW),
      .CNT_WIDTH   (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clear_stats (clear_stats),
      .correct_cnt (correct_cnt),
      .total_cnt   (total_cnt),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // Reference: first index holding the maximum wins; second = best of the rest
   function automatic ref_t model(input score_arr_t sc, input int lab);
      ref_t r;
      int best = 0;
      int second = -(1 << 30);
      for (int i = 1; i < NC; i++) if (sc[i] > sc[best]) best = i;
      for (int i = 0; i < NC; i++) if (i != best && int'(sc[i]) > second) second = sc[i];
      r.label   = best;
      r.maxv    = sc[best];
      r.correct = (lab == best);
      r.margin  = int'(sc[best]) - second;
      return r;
   endfunction

   task automatic account(input ref_t r);
      exp_total = (exp_total < CNT_MAX) ? exp_total + 1 : CNT_MAX;
      if (r.correct) exp_correct = (exp_correct < CNT_MAX) ? exp_correct + 1 : CNT_MAX;
   endtask

   task automatic drive_image(input score_arr_t sc, input int lab);
      for (int i = 0; i < NC; i++) begin
         int n = 0;
         @(negedge clk);
         bus.score_valid = 1'b1;
         bus.score_data  = sc[i];
         bus.label_in    = (i == 0) ? IW'(lab) : IW'($urandom_range(15));
         while (!bus.score_ready && n < 100) begin
            @(negedge clk);
            n++;
         end
         if (n >= 100) begin
            n_checks++;
            $display("FAIL beat_wait beat %0d: score_ready stayed %0b, required 1", i, bus.score_ready);
         end
      end
      @(negedge clk);
      bus.score_valid = 1'b0;
   endtask

   task automatic take_result(input int delay);
      repeat (delay) @(negedge clk);
      bus.result_ready = 1'b1;
      @(negedge clk);
      bus.result_ready = 1'b0;
   endtask

   task automatic rand_image(output score_arr_t sc, input bit narrow);
      for (int i = 0; i < NC; i++)
         sc[i] = narrow ? DW'(int'($urandom_range(0, 6)) - 3) : DW'($urandom);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      clear_stats = 1'b0;
      bus.score_valid = 1'b0;
      bus.score_data = '0;
      bus.label_in = '0;
      bus.result_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.score_ready !== 1'b0) $display("FAIL rst_ready got %0b want 0", bus.score_ready); else n_pass++;
      n_checks++; if (bus.result_valid !== 1'b0) $display("FAIL rst_valid got %0b want 0", bus.result_valid); else n_pass++;
      n_checks++; if (bus.result_label !== '0 || bus.result_max !== '0 || bus.result_correct !== 1'b0)
         $display("FAIL rst_result got label %0d max %0d correct %0b want 0/0/0", bus.result_label, bus.result_max, bus.result_correct);
      else n_pass++;
      n_checks++; if (total_cnt !== '0 || correct_cnt !== '0)
         $display("FAIL rst_counts got %0d/%0d want 0/0", correct_cnt, total_cnt); else n_pass++;
`ifdef CLASSIFY_SCORER_MARGIN_EN
      n_checks++; if (bus.result_margin !== '0) $display("FAIL rst_margin got %0d want 0", bus.result_margin); else n_pass++;
`endif
      rst = 1'b0;
      n_checks++; if (bus.score_ready !== 1'b0) $display("FAIL rst_release_ready got %0b want 0", bus.score_ready); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus.score_ready !== 1'b1) $display("FAIL first_edge_ready got %0b want 1", bus.score_ready); else n_pass++;
   endtask

   task automatic test_ascending;
      score_arr_t sc;
      ref_t r;
      for (int i = 0; i < NC; i++) sc[i] = DW'(100 + i);
      r = model(sc, 9);
      account(r);
      drive_image(sc, 9);
      n_checks++; if (bus.result_valid !== 1'b1) $display("FAIL asc_latency valid got %0b want 1", bus.result_valid); else n_pass++;
      n_checks++; if (bus.result_label !== IW'(9)) $display("FAIL asc_label got %0d want 9", bus.result_label); else n_pass++;
      n_checks++; if (bus.result_max !== DW'(109)) $display("FAIL asc_max got %0d want 109", bus.result_max); else n_pass++;
      n_checks++; if (bus.result_correct !== 1'b1) $display("FAIL asc_correct got %0b want 1", bus.result_correct); else n_pass++;
      n_checks++; if (correct_cnt !== CW'(1) || total_cnt !== CW'(1))
         $display("FAIL asc_counts got %0d/%0d want 1/1", correct_cnt, total_cnt); else n_pass++;
      take_result(0);
   endtask

   task automatic test_tie;
      score_arr_t sc;
      ref_t r;
      for (int i = 0; i < NC; i++) sc[i] = -16'sd5;
      sc[3] = 16'sd200;
      sc[7] = 16'sd200;
      r = model(sc, 7);
      account(r);
      drive_image(sc, 7);
      n_checks++; if (bus.result_label !== IW'(3)) $display("FAIL tie_label got %0d want 3", bus.result_label); else n_pass++;
      n_checks++; if (bus.result_max !== DW'(200)) $display("FAIL tie_max got %0d want 200", bus.result_max); else n_pass++;
      n_checks++; if (bus.result_correct !== 1'b0) $display("FAIL tie_correct got %0b want 0", bus.result_correct); else n_pass++;
      n_checks++; if (correct_cnt !== CW'(exp_correct) || total_cnt !== CW'(exp_total))
         $display("FAIL tie_counts got %0d/%0d want %0d/%0d", correct_cnt, total_cnt, exp_correct, exp_total); else n_pass++;
`ifdef CLASSIFY_SCORER_MARGIN_EN
      n_checks++; if (bus.result_margin !== '0) $display("FAIL tie_margin got %0d want 0", bus.result_margin); else n_pass++;
`endif
      take_result(1);
   endtask

   task automatic test_backpressure;
      score_arr_t sc;
      ref_t r;
      rand_image(sc, 1'b0);
      r = model(sc, $urandom_range(15));
      drive_image(sc, r.correct ? r.label : $urandom_range(15));
      bus.result_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         bus.score_valid = 1'b1;
         bus.score_data  = DW'($urandom);
         @(negedge clk);
         n_checks++; if (bus.score_ready !== 1'b0 || bus.result_valid !== 1'b1)
            $display("FAIL bp_hs cycle %0d got ready %0b valid %0b want 0/1", k, bus.score_ready, bus.result_valid); else n_pass++;
         n_checks++; if (bus.result_label !== IW'(r.label) || bus.result_max !== DW'(r.maxv))
            $display("FAIL bp_stable cycle %0d got %0d/%0d want %0d/%0d", k, bus.result_label, bus.result_max, r.label, r.maxv);
         else n_pass++;
      end
      bus.score_valid = 1'b0;
      take_result(0);
      rand_image(sc, 1'b0);
      r = model(sc, 0);
      r = model(sc, r.label);
      drive_image(sc, r.label);
      n_checks++; if (bus.result_label !== IW'(r.label) || bus.result_max !== DW'(r.maxv) || bus.result_correct !== 1'b1)
         $display("FAIL bp_next got %0d/%0d/%0b want %0d/%0d/1", bus.result_label, bus.result_max, bus.result_correct, r.label, r.maxv);
      else n_pass++;
      take_result(0);
      // counters were not modelled for these two images; resynchronise via clear
      @(negedge clk); clear_stats = 1'b1;
      @(negedge clk); clear_stats = 1'b0;
      exp_total = 0; exp_correct = 0;
   endtask

   task automatic test_random;
      score_arr_t sc;
      ref_t r;
      int lab;
      for (int t = 0; t < 8; t++) begin
         rand_image(sc, t[0]);
         r = model(sc, 0);
         lab = ($urandom_range(1) == 1) ? r.label : int'($urandom_range(15));
         r = model(sc, lab);
         account(r);
         drive_image(sc, lab);
         n_checks++; if (bus.result_label !== IW'(r.label) || bus.result_max !== DW'(r.maxv))
            $display("FAIL rnd_result img %0d got %0d/%0d want %0d/%0d", t, bus.result_label, bus.result_max, r.label, r.maxv);
         else n_pass++;
         n_checks++; if (bus.result_correct !== r.correct)
            $display("FAIL rnd_correct img %0d lab %0d got %0b want %0b", t, lab, bus.result_correct, r.correct); else n_pass++;
         n_checks++; if (correct_cnt !== CW'(exp_correct) || total_cnt !== CW'(exp_total))
            $display("FAIL rnd_counts img %0d got %0d/%0d want %0d/%0d", t, correct_cnt, total_cnt, exp_correct, exp_total);
         else n_pass++;
`ifdef CLASSIFY_SCORER_MARGIN_EN
         n_checks++; if (bus.result_margin !== (DW+1)'(r.margin))
            $display("FAIL rnd_margin img %0d got %0d want %0d", t, bus.result_margin, r.margin); else n_pass++;
`endif
         take_result($urandom_range(3));
      end
   endtask

   task automatic test_reset_mid;
      score_arr_t sc;
      ref_t r;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.score_valid = 1'b1;
         bus.score_data  = 16'sd30000;
         bus.label_in    = IW'(i);
      end
      @(negedge clk);
      bus.score_valid = 1'b0;
      rst = 1'b1;
      exp_total = 0; exp_correct = 0;
      @(negedge clk);
      n_checks++; if (total_cnt !== '0 || correct_cnt !== '0 || bus.result_label !== '0 || bus.result_max !== '0 || bus.result_correct !== 1'b0)
         $display("FAIL midrst_clear got cnt %0d/%0d res %0d/%0d/%0b want all 0", correct_cnt, total_cnt, bus.result_label, bus.result_max, bus.result_correct);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      rand_image(sc, 1'b0);
      r = model(sc, 0);
      r = model(sc, r.label);
      account(r);
      drive_image(sc, r.label);
      n_checks++; if (bus.result_label !== IW'(r.label) || bus.result_max !== DW'(r.maxv) || bus.result_correct !== 1'b1)
         $display("FAIL midrst_img got %0d/%0d/%0b want %0d/%0d/1", bus.result_label, bus.result_max, bus.result_correct, r.label, r.maxv);
      else n_pass++;
      n_checks++; if (correct_cnt !== CW'(exp_correct) || total_cnt !== CW'(exp_total))
         $display("FAIL midrst_counts got %0d/%0d want %0d/%0d", correct_cnt, total_cnt, exp_correct, exp_total); else n_pass++;
      take_result(0);
   endtask

   task automatic test_saturation;
      score_arr_t sc;
      ref_t r;
      @(negedge clk); clear_stats = 1'b1;
      @(negedge clk); clear_stats = 1'b0;
      exp_total = 0; exp_correct = 0;
      n_checks++; if (total_cnt !== '0 || correct_cnt !== '0)
         $display("FAIL clear_counts got %0d/%0d want 0/0", correct_cnt, total_cnt); else n_pass++;
      for (int t = 0; t < 20; t++) begin
         rand_image(sc, 1'b0);
         r = model(sc, 0);
         r = model(sc, r.label);
         account(r);
         drive_image(sc, r.label);
         take_result(0);
      end
      n_checks++; if (correct_cnt !== CW'(exp_correct) || total_cnt !== CW'(exp_total) || total_cnt !== CW'(CNT_MAX))
         $display("FAIL sat_counts got %0d/%0d want %0d/%0d", correct_cnt, total_cnt, exp_correct, exp_total); else n_pass++;
      rand_image(sc, 1'b0);
      r = model(sc, 0);
      clear_stats = 1'b1;
      drive_image(sc, r.label);
      clear_stats = 1'b0;
      exp_total = 0; exp_correct = 0;
      n_checks++; if (bus.result_valid !== 1'b1 || correct_cnt !== '0 || total_cnt !== '0)
         $display("FAIL clear_wins got valid %0b cnt %0d/%0d want 1 0/0", bus.result_valid, correct_cnt, total_cnt); else n_pass++;
      take_result(0);
   endtask

`ifdef CLASSIFY_SCORER_MARGIN_EN
   task automatic test_margin;
      score_arr_t sc;
      ref_t r;
      int a, b;
      a = $urandom_range(NC - 1);
      b = (a + 1 + int'($urandom_range(NC - 2))) % NC;
      for (int i = 0; i < NC; i++) sc[i] = DW'(int'($urandom_range(0, 1400)) - 1000);
      sc[a] = 16'sd500;
      sc[b] = 16'sd480;
      r = model(sc, a);
      drive_image(sc, a);
      n_checks++; if (bus.result_margin !== 17'd20 || r.margin != 20)
         $display("FAIL margin_20 got %0d want 20", bus.result_margin); else n_pass++;
      take_result(0);
      for (int i = 0; i < NC; i++) sc[i] = -16'sd32768;
      sc[a] = 16'sd32767;
      r = model(sc, a);
      drive_image(sc, a);
      n_checks++; if (bus.result_margin !== (DW+1)'(r.margin))
         $display("FAIL margin_full got %0d want %0d", bus.result_margin, r.margin); else n_pass++;
      take_result(0);
      @(negedge clk); clear_stats = 1'b1;
      @(negedge clk); clear_stats = 1'b0;
      exp_total = 0; exp_correct = 0;
   endtask
`endif

   initial begin
      test_reset();
      test_ascending();
      test_tie();
      test_backpressure();
      test_random();
`ifdef CLASSIFY_SCORER_MARGIN_EN
      test_margin();
`endif
      test_reset_mid();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
